// File: rtl/hline_pkg.sv
// ============================================================================
// Module : hline_pkg
// Desc   : Shared constants and state encoding for the span setup stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hline_pkg;

    localparam int unsigned DEF_STRIDE_BYTES = 2560;
    localparam int unsigned DEF_XW           = 16;
    localparam int unsigned DIV_CYCLES       = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_WAIT_DN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hline_setup_if.sv
// ============================================================================
// Module : hline_setup_if
// Desc   : Command handshake and walker launch bundle of the span setup stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hline_setup_if
    import hline_pkg::*;
#(
    parameter int unsigned XW = DEF_XW
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] x1;
    logic [XW-1:0] x2;
    logic [XW-1:0] y;
    logic [31:0]   z1_in;
    logic [31:0]   z2_in;
    logic [31:0]   fb_base;
    logic [31:0]   zbuff_base;
    logic          dn_idle;
    logic          start;
    logic [31:0]   fb_addr;
    logic [31:0]   zbuff_addr;
    logic [31:0]   dx;
    logic [31:0]   slope;
    logic [31:0]   rem;
    logic [31:0]   err;
    logic [31:0]   z1;
    logic          busy;

    modport slave (
        input  cmd_valid, x1, x2, y, z1_in, z2_in, fb_base, zbuff_base, dn_idle,
        output cmd_ready, start, fb_addr, zbuff_addr, dx, slope, rem, err, z1, busy
    );

    modport master (
        output cmd_valid, x1, x2, y, z1_in, z2_in, fb_base, zbuff_base, dn_idle,
        input  cmd_ready, start, fb_addr, zbuff_addr, dx, slope, rem, err, z1, busy
    );

endinterface

`default_nettype wire

// File: rtl/hline_div.sv
// ============================================================================
// Module : hline_div
// Desc   : 32-by-XW restoring divider, one quotient bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hline_div
    import hline_pkg::*;
#(
    parameter int unsigned XW = DEF_XW
) (
    input  wire logic          clk,
    input  wire logic          nreset,
    input  wire logic          go,
    input  wire logic [31:0]   dividend,
    input  wire logic [XW-1:0] divisor,
    output logic               done,
    output logic [31:0]        quotient,
    output logic [XW-1:0]      remainder
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [31:0]   r_q;
    logic [XW-1:0] r_rem;
    logic [XW-1:0] r_divisor;
    logic [CW-1:0] r_count;
    logic          r_done;

    logic [31:0]   w_src;
    logic [XW-1:0] w_div;
    logic [XW:0]   w_shift;
    logic          w_ge;
    logic [XW:0]   w_new_rem;

    // The go cycle already retires the first quotient bit, so 32 bits finish
    // 31 edges after go and done is visible one cycle later.
    always_comb begin
        w_src     = go ? dividend : r_q;
        w_div     = go ? divisor : r_divisor;
        w_shift   = go ? {{XW{1'b0}}, dividend[31]} : {r_rem, r_q[31]};
        w_ge      = (w_shift >= {1'b0, w_div});
        w_new_rem = w_ge ? (w_shift - {1'b0, w_div}) : w_shift;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_q       <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else if (go) begin
            r_q       <= {w_src[30:0], w_ge};
            r_rem     <= w_new_rem[XW-1:0];
            r_divisor <= divisor;
            r_count   <= CW'(DIV_CYCLES - 1);
            r_done    <= 1'b0;
        end else if (r_count != '0) begin
            r_q       <= {w_src[30:0], w_ge};
            r_rem     <= w_new_rem[XW-1:0];
            r_count   <= r_count - 1'b1;
            r_done    <= (r_count == CW'(1));
        end else begin
            r_done    <= 1'b0;
        end
    end

    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/hline_setup.sv
// ============================================================================
// Module : hline_setup
// Desc   : Orders span endpoints, divides depth delta by span length and
//          forms start addresses before launching the z-buffer walker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hline_setup
    import hline_pkg::*;
#(
    parameter int unsigned STRIDE_BYTES = DEF_STRIDE_BYTES,
    parameter int unsigned XW           = DEF_XW
) (
    input  wire logic clk,
    input  wire logic nreset,
    hline_setup_if.slave bus
);

    state_t        r_state;
    logic [31:0]   r_fb_addr;
    logic [31:0]   r_zbuff_addr;
    logic [31:0]   r_dx;
    logic [31:0]   r_slope;
    logic [31:0]   r_rem;
    logic [31:0]   r_err;
    logic [31:0]   r_z1;
    logic          r_neg;

    logic          w_accept;
    logic          w_swap;
    logic [XW-1:0] w_xs;
    logic [XW-1:0] w_xe;
    logic [31:0]   w_zs;
    logic [31:0]   w_ze;
    logic [XW-1:0] w_dx;
    logic [32:0]   w_dz;
    logic [31:0]   w_abs_dz;
    logic [31:0]   w_row;
    logic [31:0]   w_xoff;
    logic          w_div_go;
    logic          w_div_done;
    logic [31:0]   w_div_q;
    logic [XW-1:0] w_div_rem;

    always_comb begin
        w_accept = bus.cmd_valid && (r_state == ST_IDLE);
        // Equal x keeps x1 as the left end so zs follows z1_in.
        w_swap   = (bus.x2 < bus.x1);
        w_xs     = w_swap ? bus.x2 : bus.x1;
        w_xe     = w_swap ? bus.x1 : bus.x2;
        w_zs     = w_swap ? bus.z2_in : bus.z1_in;
        w_ze     = w_swap ? bus.z1_in : bus.z2_in;
        w_dx     = w_xe - w_xs;
        w_dz     = {1'b0, w_ze} - {1'b0, w_zs};
        w_abs_dz = w_dz[32] ? (~w_dz[31:0] + 32'd1) : w_dz[31:0];
        w_row    = 32'(bus.y) * 32'(STRIDE_BYTES);
        w_xoff   = 32'(w_xs) << 2;
        w_div_go = w_accept && (w_dx != '0);
    end

    hline_div #(
        .XW (XW)
    ) u_div (
        .clk       (clk),
        .nreset    (nreset),
        .go        (w_div_go),
        .dividend  (w_abs_dz),
        .divisor   (w_dx),
        .done      (w_div_done),
        .quotient  (w_div_q),
        .remainder (w_div_rem)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_fb_addr    <= '0;
            r_zbuff_addr <= '0;
            r_dx         <= '0;
            r_slope      <= '0;
            r_rem        <= '0;
            r_err        <= '0;
            r_z1         <= '0;
            r_neg        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fb_addr    <= bus.fb_base + w_row + w_xoff;
                        r_zbuff_addr <= bus.zbuff_base + w_row + w_xoff;
                        r_dx         <= 32'(w_dx);
                        r_err        <= 32'(w_dx >> 1);
                        r_z1         <= w_zs;
                        r_neg        <= w_dz[32];
                        if (w_dx == '0) begin
                            r_slope <= '0;
                            r_rem   <= '0;
                            r_state <= ST_WAIT_DN;
                        end else begin
                            r_state <= ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (w_div_done) begin
                        r_slope <= r_neg ? (32'd0 - w_div_q) : w_div_q;
                        r_rem   <= 32'(w_div_rem);
                        r_state <= ST_WAIT_DN;
                    end
                end
                ST_WAIT_DN: begin
                    if (bus.dn_idle) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.start      = (r_state == ST_WAIT_DN) && bus.dn_idle;
    assign bus.fb_addr    = r_fb_addr;
    assign bus.zbuff_addr = r_zbuff_addr;
    assign bus.dx         = r_dx;
    assign bus.slope      = r_slope;
    assign bus.rem        = r_rem;
    assign bus.err        = r_err;
    assign bus.z1         = r_z1;

endmodule

`default_nettype wire

// File: doc/hline_setup.md
# hline_setup

Per-line setup stage in front of the horizontal-line z-buffer walker. It accepts one raw span command per handshake: endpoints x1 and x2, scanline y, endpoint depths, and the frame-buffer and z-buffer base addresses. It orders the endpoints and computes the integer depth slope and remainder with a sequential divider. It also forms the byte addresses of the span start, then pulses `start` to the walker once that walker is idle.

## Interface
Parameters:
- STRIDE_BYTES, 2560: bytes per scanline, identical for the frame buffer and the z-buffer.
- XW, 16: width of the x and y coordinates and of dx.

Ports:
- clk  in  1  single clock for the whole block.
- nreset  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  a span command is present.
- cmd_ready  out  1  the block can accept a command. High only in IDLE.
- x1, x2, y  in  XW  span endpoints and scanline.
- z1_in, z2_in  in  32  unsigned depth at x1 and at x2.
- fb_base, zbuff_base  in  32  base byte addresses.
- dn_idle  in  1  the downstream walker is in its IDLE state.
- start  out  1  one-cycle launch pulse to the walker.
- fb_addr, zbuff_addr  out  32  byte address of the span start in each buffer.
- dx  out  32  span length, zero-extended from XW bits.
- slope  out  32  signed per-pixel depth increment.
- rem  out  32  remainder of |dz| / dx.
- err  out  32  initial error term.
- z1  out  32  depth at the left end of the span.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DIVIDE, WAIT_DN.
- IDLE:
  - On cmd_valid && cmd_ready, register the command.
  - Order the endpoints: xs = min(x1,x2), xe = max(x1,x2). zs is the depth of the xs endpoint, ze the depth of xe. When x1 == x2, zs = z1_in.
  - dx = xe − xs.
  - dz = ze − zs, computed as a 33-bit signed value.
- Address arithmetic, registered in the accept cycle:
  - row = y·STRIDE_BYTES.
  - fb_addr = fb_base + row + 4·xs.
  - zbuff_addr = zbuff_base + row + 4·xs.
  - All sums wrap modulo 2^32.
- Outputs set in the accept cycle: z1 = zs, err = dx >> 1.
- Next state from IDLE:
  - If dx == 0: slope = 0, rem = 0, go to WAIT_DN.
  - Otherwise: start the divider on dividend |dz| (32 bits, unsigned) and divisor dx, go to DIVIDE.
- DIVIDE:
  - Restoring division, one quotient bit per cycle, exactly 32 cycles.
  - Then slope = (dz < 0) ? −q : q and rem = r, go to WAIT_DN.
- WAIT_DN: start = dn_idle (combinational). When dn_idle is high, go to IDLE on that edge.
- Commands arriving while not in IDLE are ignored (cmd_ready is low).
- Outputs to the walker hold their values from entry to WAIT_DN until the next command is accepted.

## Timing
- Reset value of every register and output is 0: start, busy, all data outputs, the divider state. The exception is cmd_ready, which is 1 because the state resets to IDLE.
- Reset asserted in any state aborts the operation immediately. No start is issued for an aborted command.
- Accept edge is T:
  - dx != 0: DIVIDE occupies cycles T+1..T+32, and WAIT_DN is entered at T+33.
  - dx == 0: WAIT_DN is entered at T+1.
- Minimum latency from the accept edge to the start pulse: 33 cycles, or 1 cycle when dx == 0.
- start is high for exactly one cycle per accepted command. It is never high outside WAIT_DN.
- cmd_ready returns high in the cycle after start.
- If dn_idle is low, the block stays in WAIT_DN indefinitely, with outputs stable.
- Width rules:
  - The quotient fits in 32 bits because |dz| ≤ 2^32−1.
  - rem < dx ≤ 2^XW−1.
  - −q is computed in two's complement over 32 bits.

## Structure
- Package `hline_pkg`:
  - State encoding.
  - STRIDE_BYTES default.
  - DIV_CYCLES = 32.
  - XW.
- Sub-module `hline_div`, a 32-by-XW restoring divider:
  - Inputs: go, dividend, divisor.
  - Outputs: done (one-cycle pulse), quotient, remainder.
  - Reset: asynchronous, active-low.

## Test plan
- x1=10, x2=20, y=3, z1_in=100, z2_in=150, fb_base=0x1000_0000, zbuff_base=0x2000_0000 → dx=10, slope=5, rem=0, err=5, z1=100, fb_addr=0x1000_1E28, zbuff_addr=0x2000_1E28; start at T+33 with dn_idle=1.
- Same span with the endpoints swapped (x1=20, z1_in=150, x2=10, z2_in=100) → identical outputs to the previous case.
- x1=0, x2=3, z1_in=10, z2_in=0 → slope=0xFFFF_FFFD, rem=1, err=1, z1=10.
- x1=x2=5, y=0 → dx=0, slope=0, rem=0, err=0, fb_addr=fb_base+20; start at T+1.
- dn_idle held low for 10 cycles after the divide completes → no start during those cycles, outputs stable, cmd_ready low, and a second cmd_valid is ignored. start pulses in the cycle dn_idle rises.
- nreset pulsed low at T+10, mid-DIVIDE → all outputs 0 and cmd_ready=1 after release. No start follows, and the next command is processed normally.
